// File: rtl/regfile_wb_pkg.sv
// Shared types and helpers for the register-file write-back path: load funct3
// codes, the queued write entry, and load byte/halfword extraction.
package regfile_wb_pkg;

    localparam int WB_XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // Unlisted funct3 encodings fall back to a full-word load.
    function automatic logic [WB_XLEN-1:0] load_extend(
        input logic [WB_XLEN-1:0] data,
        input logic [2:0]         funct3,
        input logic [1:0]         addr_lo
    );
        logic [7:0]         byte_sel;
        logic [15:0]        half_sel;
        logic [WB_XLEN-1:0] result;
        case (addr_lo)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            LB:      result = {{(WB_XLEN-8){byte_sel[7]}}, byte_sel};
            LH:      result = {{(WB_XLEN-16){half_sel[15]}}, half_sel};
            LBU:     result = {{(WB_XLEN-8){1'b0}}, byte_sel};
            LHU:     result = {{(WB_XLEN-16){1'b0}}, half_sel};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/regfile_writeback_load_queue.sv
// wb_load_queue: circular FIFO of extended load results, with a per-entry
// valid/rd view so the top can answer pending-destination queries.
module wb_load_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [DEPTH-1:0][4:0] entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    wb_entry_t        mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign head_entry = mem[rd_ptr_reg];
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);

    // An entry is live when its distance from the read pointer is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
            assign entry_rd[gi]    = mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU results take priority, loads drain from
// a small queue. Optional same-edge load bypass under REGFILE_WB_BYPASS_EN.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4,
    parameter int XLEN     = WB_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [4:0]      query_reg,
    output logic            query_hit,
    output logic            RegWrite,
    output logic [4:0]      write_register,
    output logic [XLEN-1:0] write_data
);

    logic                     alu_write;
    logic                     ld_accept;
    logic                     ld_bypass;
    wb_entry_t                ld_entry;
    logic                     lq_push;
    logic                     lq_pop;
    wb_entry_t                lq_head;
    logic                     lq_full;
    logic                     lq_empty;
    logic [LQ_DEPTH-1:0]      lq_valid;
    logic [LQ_DEPTH-1:0][4:0] lq_rd;
    logic [LQ_DEPTH-1:0]      entry_hit;

    logic            we_reg,   we_next;
    logic [4:0]      rd_reg,   rd_next;
    logic [XLEN-1:0] data_reg, data_next;

    // Writes to x0 are meaningless, so they never claim the port.
    assign alu_write = alu_valid && (alu_rd != 5'd0);
    assign ld_ready  = !lq_full;
    assign ld_accept = ld_valid && ld_ready;

    assign ld_entry.rd   = ld_rd;
    assign ld_entry.data = load_extend(ld_data, ld_funct3, ld_addr_lo);

`ifdef REGFILE_WB_BYPASS_EN
    assign ld_bypass = ld_accept && lq_empty && !alu_write && (ld_rd != 5'd0);
`else
    assign ld_bypass = 1'b0;
`endif

    assign lq_push = ld_accept && (ld_rd != 5'd0) && !ld_bypass;

    wb_load_queue #(
        .DEPTH(LQ_DEPTH)
    ) u_load_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (lq_push),
        .push_entry (ld_entry),
        .pop        (lq_pop),
        .head_entry (lq_head),
        .full       (lq_full),
        .empty      (lq_empty),
        .entry_valid(lq_valid),
        .entry_rd   (lq_rd)
    );

    // Bypass only fires with an empty queue, so it can never reorder loads.
    always_comb begin
        we_next   = 1'b0;
        rd_next   = 5'd0;
        data_next = '0;
        lq_pop    = 1'b0;
        if (alu_write) begin
            we_next   = 1'b1;
            rd_next   = alu_rd;
            data_next = alu_result;
        end else if (!lq_empty) begin
            lq_pop    = 1'b1;
            we_next   = 1'b1;
            rd_next   = lq_head.rd;
            data_next = lq_head.data;
        end else if (ld_bypass) begin
            we_next   = 1'b1;
            rd_next   = ld_entry.rd;
            data_next = ld_entry.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg   <= 1'b0;
            rd_reg   <= 5'd0;
            data_reg <= '0;
        end else begin
            we_reg   <= we_next;
            rd_reg   <= rd_next;
            data_reg <= data_next;
        end
    end

    assign RegWrite       = we_reg;
    assign write_register = rd_reg;
    assign write_data     = data_reg;

    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_hit
            assign entry_hit[gi] = lq_valid[gi] && (lq_rd[gi] == query_reg);
        end
    endgenerate

    assign query_hit = (query_reg != 5'd0) &&
                       ((|entry_hit) || (we_reg && (rd_reg == query_reg)));

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int EXP_LAT = BYP ? 1 : 2;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [4:0]  query_reg;
    logic        query_hit;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_writeback #(
        .LQ_DEPTH(DEPTH),
        .XLEN    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_result    (alu_result),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_funct3     (ld_funct3),
        .ld_addr_lo    (ld_addr_lo),
        .query_reg     (query_reg),
        .query_hit     (query_hit),
        .RegWrite      (RegWrite),
        .write_register(write_register),
        .write_data    (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending writes as a plain FIFO of (rd, value).
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      m_q[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic logic [31:0] m_extend(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (d >> (8 * int'(lo))) & 32'h0000_00FF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (d >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    initial begin
        m_we = 1'b0; m_rd = '0; m_data = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_we = 1'b0; m_rd = '0; m_data = '0;
            end else begin
                bit     alu_w, accept, bypassed;
                m_ent_t e;
                alu_w    = alu_valid && (alu_rd != 0);
                accept   = ld_valid && (m_q.size() < DEPTH);
                e.rd     = ld_rd;
                e.data   = m_extend(ld_data, ld_funct3, ld_addr_lo);
                bypassed = 1'b0;
                if (alu_w) begin
                    m_we = 1'b1; m_rd = alu_rd; m_data = alu_result;
                end else if (m_q.size() > 0) begin
                    m_ent_t h;
                    h = m_q.pop_front();
                    m_we = 1'b1; m_rd = h.rd; m_data = h.data;
                end else if (BYP && accept && ld_rd != 0) begin
                    m_we = 1'b1; m_rd = e.rd; m_data = e.data; bypassed = 1'b1;
                end else begin
                    m_we = 1'b0; m_rd = '0; m_data = '0;
                end
                if (accept && ld_rd != 0 && !bypassed) m_q.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                bit exp_hit;
                exp_hit = 1'b0;
                if (query_reg != 0) begin
                    if (m_we && m_rd == query_reg) exp_hit = 1'b1;
                    foreach (m_q[i]) if (m_q[i].rd == query_reg) exp_hit = 1'b1;
                end
                check("cyc_we",    {31'b0, RegWrite},       {31'b0, m_we});
                check("cyc_rd",    {27'b0, write_register}, {27'b0, m_rd});
                check("cyc_data",  write_data,              m_data);
                check("cyc_ready", {31'b0, ld_ready},       {31'b0, (m_q.size() < DEPTH)});
                check("cyc_hit",   {31'b0, query_hit},      {31'b0, exp_hit});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_txn(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] lo, input logic [31:0] d, input logic [31:0] exp);
        int lat;
        bit found;
        tick();
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo; ld_data = d;
        tick();
        ld_valid = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (RegWrite === 1'b1 && write_register === rd) begin
                found = 1'b1;
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({nm, "_seen"}, {31'b0, found}, 32'd1);
        check({nm, "_data"}, write_data, exp);
        check({nm, "_lat"}, lat, EXP_LAT);
        $display("txn %s rd=%0d f3=%b lo=%0d data=%h -> %h lat=%0d", nm, rd, f3, lo, d, write_data, lat);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; ld_funct3 = '0; ld_addr_lo = '0;
        query_reg = '0;

        check("pin_lb",  m_extend(32'h80FF7F01, 3'b000, 2'd3), 32'hFFFFFF80);
        check("pin_lbu", m_extend(32'h80FF7F01, 3'b100, 2'd3), 32'h00000080);
        check("pin_lh",  m_extend(32'h80FF7F01, 3'b001, 2'd2), 32'hFFFF80FF);
        check("pin_lhu", m_extend(32'h80FF7F01, 3'b101, 2'd0), 32'h00007F01);
        check("pin_lb1", m_extend(32'h80FF7F01, 3'b000, 2'd1), 32'h0000007F);

        repeat (3) tick();
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("idle_we",    {31'b0, RegWrite}, 32'd0);
        check("idle_data",  write_data,        32'd0);
        check("idle_ready", {31'b0, ld_ready}, 32'd1);
        $display("txn reset/idle we=%b data=%h ready=%b", RegWrite, write_data, ld_ready);

        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("alu_we",   {31'b0, RegWrite},       32'd1);
        check("alu_rd",   {27'b0, write_register}, 32'd5);
        check("alu_data", write_data,              32'h1234);
        $display("txn alu rd=5 -> we=%b rd=%0d data=%h", RegWrite, write_register, write_data);

        tick();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hDEAD;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("alu_x0_we", {31'b0, RegWrite}, 32'd0);
        $display("txn alu rd=0 -> we=%b", RegWrite);

        load_txn("lb",   5'd3, 3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80);
        load_txn("lbu",  5'd4, 3'b100, 2'd3, 32'h80FF7F01, 32'h00000080);
        load_txn("lh",   5'd6, 3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF);
        load_txn("lhu",  5'd8, 3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01);
        load_txn("lw",   5'd3, 3'b010, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
        load_txn("f011", 5'd9, 3'b011, 2'd1, 32'h12345678, 32'h12345678);

        // ALU busy for six cycles while loads fill the queue.
        tick();
        query_reg = 5'd22;
        alu_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_rd = 5'(10 + i); alu_result = 32'(1000 + i);
            ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
            ld_rd = (i < 4) ? 5'(20 + i) : 5'd24;
            ld_data = (i < 4) ? 32'hA000_0000 + 32'(i) : 32'h0000_00B0;
            tick();
            if (i == 3 || i == 4) begin
                @(negedge clk);
                check("full_ready", {31'b0, ld_ready}, 32'd0);
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        @(negedge clk);
        check("drain_rd0",    {27'b0, write_register}, 32'd20);
        check("drain_data0",  write_data,              32'hA000_0000);
        check("drain_ready",  {31'b0, ld_ready},       32'd1);
        $display("txn drain rd=%0d data=%h ready=%b", write_register, write_data, ld_ready);
        for (int j = 1; j < 4; j++) begin
            tick();
            @(negedge clk);
            check("drain_rd", {27'b0, write_register}, 32'(20 + j));
            $display("txn drain rd=%0d data=%h", write_register, write_data);
        end
        tick();
        @(negedge clk);
        check("drain_done", {31'b0, RegWrite}, 32'd0);

        // Pending-destination query for a load held behind the ALU.
        tick();
        query_reg = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'd1;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        check("q_hit_queued", {31'b0, query_hit}, 32'd1);
        tick();
        @(negedge clk);
        check("q_hit_queued2", {31'b0, query_hit}, 32'd1);
        alu_valid = 1'b0;
        tick();
        @(negedge clk);
        check("q_we7",  {27'b0, write_register}, 32'd7);
        check("q_hit_out", {31'b0, query_hit}, 32'd1);
        tick();
        @(negedge clk);
        check("q_hit_gone", {31'b0, query_hit}, 32'd0);
        query_reg = 5'd0;
        #1;
        check("q_hit_x0", {31'b0, query_hit}, 32'd0);
        $display("txn query rd=7 done");

        // Reset asserted with three loads queued behind the ALU.
        tick();
        query_reg = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h55;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_funct3 = 3'b010; ld_data = 32'(i + 1);
            tick();
        end
        ld_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_we", {31'b0, RegWrite}, 32'd1);
        check("pre_rst_hit", {31'b0, query_hit}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_we",   {31'b0, RegWrite},       32'd0);
        check("rst_rd",   {27'b0, write_register}, 32'd0);
        check("rst_data", write_data,              32'd0);
        tick();
        tick();
        alu_valid = 1'b0;
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_we",    {31'b0, RegWrite},  32'd0);
        check("post_rst_ready", {31'b0, ld_ready},  32'd1);
        check("post_rst_hit",   {31'b0, query_hit}, 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_we2", {31'b0, RegWrite}, 32'd0);
        $display("txn mid-stream reset done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
